// File: rtl/m_stage_dmem_pkg.sv
// +----------------------------------------------------------------------------
// | m_stage_dmem_pkg
// | Opcodes, exception codes and reset constants shared by the MEM stage.
// | Revision: 1.0
// +----------------------------------------------------------------------------
`default_nettype none

package m_stage_dmem_pkg;

  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;

  localparam logic [31:0] PC4_RESET = 32'h0000_3004;
  localparam logic [31:0] PC8_RESET = 32'h0000_3008;

  function automatic logic isLoad(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_LB) || (op == OP_LBU) ||
           (op == OP_LH) || (op == OP_LHU);
  endfunction

  function automatic logic isStore(input logic [5:0] op);
    return (op == OP_SW) || (op == OP_SB) || (op == OP_SH);
  endfunction

endpackage

`default_nettype wire

// File: rtl/dm_load_ext.sv
// +----------------------------------------------------------------------------
// | dm_load_ext
// | Byte/halfword lane select with sign or zero extension for loads.
// | Revision: 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module dm_load_ext
  import m_stage_dmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr,
  input  logic [5:0]  opcode,
  output logic [31:0] value
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Little-endian: lane 0 is bits [7:0]
  assign w_byte = word[8*addr +: 8];
  assign w_half = addr[1] ? word[31:16] : word[15:0];

  always_comb begin
    value = word;
    case (opcode)
      OP_LB:   value = {{24{w_byte[7]}}, w_byte};
      OP_LBU:  value = {24'h0, w_byte};
      OP_LH:   value = {{16{w_half[15]}}, w_half};
      OP_LHU:  value = {16'h0, w_half};
      default: value = word;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/m_stage_dmem.sv
// +----------------------------------------------------------------------------
// | m_stage_dmem
// | MIPS MEM stage: data memory load/store, address-error detection, MEM/WB reg.
// | Optional DM_TRACE_EN: prints every committed store (simulation only).
// | Revision: 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module m_stage_dmem
  import m_stage_dmem_pkg::*;
#(
  parameter int          DM_WORDS = 4096,
  parameter logic [31:0] DM_BASE  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Int,
  input  logic [31:0] InstrM,
  input  logic [31:0] PCplus4M,
  input  logic [31:0] PCplus8M,
  input  logic [31:0] ALUOutM,
  input  logic        movWriteM,
  input  logic        bWriteM,
  input  logic [31:0] ReadData2M,
  output logic [4:0]  ExcM,
  output logic [31:0] InstrW,
  output logic [31:0] PCplus4W,
  output logic [31:0] PCplus8W,
  output logic [31:0] ALUOutW,
  output logic [31:0] DMOutW,
  output logic        movWriteW,
  output logic        bWriteW
);

  localparam int          c_AW       = $clog2(DM_WORDS);
  localparam logic [32:0] c_DM_BYTES = 33'(DM_WORDS) << 2;

  logic [31:0] r_mem [DM_WORDS];

  logic [5:0]      w_op;
  logic [31:0]     w_off;
  logic [c_AW-1:0] w_wordIdx;
  logic            w_isLoad;
  logic            w_isStore;
  logic            w_misalign;
  logic            w_outOfRange;
  logic            w_fault;
  logic            w_commit;
  logic [31:0]     w_rdWord;
  logic [31:0]     w_storeData;
  logic [3:0]      w_laneWe;
  logic [31:0]     w_mergedWord;
  logic [31:0]     w_loadValue;

  assign w_op         = InstrM[31:26];
  assign w_off        = ALUOutM - DM_BASE;
  assign w_wordIdx    = w_off[c_AW+1:2];
  assign w_isLoad     = isLoad(w_op);
  assign w_isStore    = isStore(w_op);
  assign w_outOfRange = {1'b0, w_off} >= c_DM_BYTES;

  always_comb begin
    w_misalign = 1'b0;
    case (w_op)
      OP_LW, OP_SW:          w_misalign = (ALUOutM[1:0] != 2'b00);
      OP_LH, OP_LHU, OP_SH:  w_misalign = ALUOutM[0];
      default:               w_misalign = 1'b0;
    endcase
  end

  always_comb begin
    ExcM = EXC_NONE;
    if (w_isLoad && (w_misalign || w_outOfRange))
      ExcM = EXC_ADEL;
    else if (w_isStore && (w_misalign || w_outOfRange))
      ExcM = EXC_ADES;
  end

  assign w_fault  = (ExcM != EXC_NONE);
  assign w_commit = w_isStore && !w_fault && !reset && !Int;
  assign w_rdWord = r_mem[w_wordIdx];

  always_comb begin
    w_laneWe    = 4'b0000;
    w_storeData = {4{ReadData2M[7:0]}};
    case (w_op)
      OP_SW: begin
        w_laneWe    = 4'b1111;
        w_storeData = ReadData2M;
      end
      OP_SH: begin
        w_laneWe    = ALUOutM[1] ? 4'b1100 : 4'b0011;
        w_storeData = {2{ReadData2M[15:0]}};
      end
      OP_SB: begin
        w_laneWe    = 4'b0001 << ALUOutM[1:0];
        w_storeData = {4{ReadData2M[7:0]}};
      end
      default: begin
        w_laneWe    = 4'b0000;
        w_storeData = {4{ReadData2M[7:0]}};
      end
    endcase
  end

  // Read-modify-write merge keeps untouched lanes of the current word
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign w_mergedWord[8*gi +: 8] = w_laneWe[gi] ? w_storeData[8*gi +: 8]
                                                  : w_rdWord[8*gi +: 8];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DM_WORDS; i++)
        r_mem[i] <= 32'h0;
    end else if (w_commit) begin
      r_mem[w_wordIdx] <= w_mergedWord;
    end
  end

`ifdef DM_TRACE_EN
  always_ff @(posedge clk) begin
    if (w_commit)
      $display("@%h: *%h <= %h", PCplus4M - 32'd4, {ALUOutM[31:2], 2'b00},
               w_mergedWord);
  end
`else
`endif

  dm_load_ext u_load_ext (
    .word   (w_rdWord),
    .addr   (ALUOutM[1:0]),
    .opcode (w_op),
    .value  (w_loadValue)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      InstrW    <= 32'h0;
      ALUOutW   <= 32'h0;
      DMOutW    <= 32'h0;
      movWriteW <= 1'b0;
      bWriteW   <= 1'b0;
      PCplus4W  <= PC4_RESET;
      PCplus8W  <= PC8_RESET;
    end else if (Int) begin
      InstrW    <= 32'h0;
      ALUOutW   <= 32'h0;
      DMOutW    <= 32'h0;
      movWriteW <= 1'b0;
      bWriteW   <= 1'b0;
    end else begin
      // A faulting access moves on as a bubble so WB never commits it
      InstrW    <= w_fault ? 32'h0 : InstrM;
      ALUOutW   <= ALUOutM;
      DMOutW    <= (w_isLoad && !w_fault) ? w_loadValue : 32'h0;
      movWriteW <= movWriteM && !w_fault;
      bWriteW   <= bWriteM && !w_fault;
      PCplus4W  <= PCplus4M;
      PCplus8W  <= PCplus8M;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_m_stage_dmem.sv
// +----------------------------------------------------------------------------
// | tb_m_stage_dmem
// | Directed vector table plus reset sequences for the MEM stage.
// | Revision: 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module tb_m_stage_dmem;

  logic        clk = 1'b0;
  logic        reset;
  logic        Int;
  logic [31:0] InstrM, PCplus4M, PCplus8M, ALUOutM, ReadData2M;
  logic        movWriteM, bWriteM;
  logic [4:0]  ExcM;
  logic [31:0] InstrW, PCplus4W, PCplus8W, ALUOutW, DMOutW;
  logic        movWriteW, bWriteW;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  m_stage_dmem dut (
    .clk        (clk),
    .reset      (reset),
    .Int        (Int),
    .InstrM     (InstrM),
    .PCplus4M   (PCplus4M),
    .PCplus8M   (PCplus8M),
    .ALUOutM    (ALUOutM),
    .movWriteM  (movWriteM),
    .bWriteM    (bWriteM),
    .ReadData2M (ReadData2M),
    .ExcM       (ExcM),
    .InstrW     (InstrW),
    .PCplus4W   (PCplus4W),
    .PCplus8W   (PCplus8W),
    .ALUOutW    (ALUOutW),
    .DMOutW     (DMOutW),
    .movWriteW  (movWriteW),
    .bWriteW    (bWriteW)
  );

  localparam logic [5:0] LW = 6'b100011, LB = 6'b100000, LBU = 6'b100100;
  localparam logic [5:0] LH = 6'b100001, LHU = 6'b100101;
  localparam logic [5:0] SW = 6'b101011, SB = 6'b101000, SH = 6'b101001;
  localparam logic [5:0] ADDIU = 6'b001001;

  typedef struct {
    logic        intr;
    logic [5:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
    logic [4:0]  exc;
    logic [31:0] dm;
  } vec_t;

  localparam int NV = 26;
  vec_t vecs[NV];

  function automatic vec_t mk(input logic intr, input logic [5:0] op,
                              input logic [31:0] addr, input logic [31:0] data,
                              input logic [4:0] exc, input logic [31:0] dm);
    vec_t v;
    v.intr = intr; v.op = op; v.addr = addr; v.data = data;
    v.exc = exc; v.dm = dm;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic intr, input logic [5:0] op,
                       input logic [31:0] addr, input logic [31:0] data,
                       input logic [31:0] pc4, input logic mw, input logic bw);
    reset      = rst;
    Int        = intr;
    InstrM     = {op, 26'h2A51234};
    PCplus4M   = pc4;
    PCplus8M   = pc4 + 32'd4;
    ALUOutM    = addr;
    ReadData2M = data;
    movWriteM  = mw;
    bWriteM    = bw;
  endtask

  task automatic checkResetState(input string tag);
    chk({tag, " InstrW"},    InstrW,    32'h0);
    chk({tag, " ALUOutW"},   ALUOutW,   32'h0);
    chk({tag, " DMOutW"},    DMOutW,    32'h0);
    chk({tag, " PCplus4W"},  PCplus4W,  32'h3004);
    chk({tag, " PCplus8W"},  PCplus8W,  32'h3008);
    chk({tag, " movWriteW"}, {31'h0, movWriteW}, 32'h0);
    chk({tag, " bWriteW"},   {31'h0, bWriteW},   32'h0);
  endtask

  initial begin
    logic [31:0] instr, pc4, expPc4;
    logic        bubble, mw, bw;
    vec_t        v;

    vecs[0]  = mk(0, SW,    32'h10,   32'h8899AABB, 5'd0, 32'h0);
    vecs[1]  = mk(0, LW,    32'h10,   32'h0,        5'd0, 32'h8899AABB);
    vecs[2]  = mk(0, SB,    32'h12,   32'h000000F0, 5'd0, 32'h0);
    vecs[3]  = mk(0, LB,    32'h12,   32'h0,        5'd0, 32'hFFFFFFF0);
    vecs[4]  = mk(0, LBU,   32'h12,   32'h0,        5'd0, 32'h000000F0);
    vecs[5]  = mk(0, LW,    32'h10,   32'h0,        5'd0, 32'h88F0AABB);
    vecs[6]  = mk(0, SH,    32'h16,   32'h00008001, 5'd0, 32'h0);
    vecs[7]  = mk(0, LH,    32'h16,   32'h0,        5'd0, 32'hFFFF8001);
    vecs[8]  = mk(0, LHU,   32'h16,   32'h0,        5'd0, 32'h00008001);
    vecs[9]  = mk(0, LW,    32'h11,   32'h0,        5'd4, 32'h0);
    vecs[10] = mk(0, SH,    32'h13,   32'h00001234, 5'd5, 32'h0);
    vecs[11] = mk(0, LW,    32'h10,   32'h0,        5'd0, 32'h88F0AABB);
    vecs[12] = mk(0, SW,    32'h4000, 32'hDEADBEEF, 5'd5, 32'h0);
    vecs[13] = mk(0, LW,    32'h0,    32'h0,        5'd0, 32'h0);
    vecs[14] = mk(1, SW,    32'h20,   32'h11223344, 5'd0, 32'h0);
    vecs[15] = mk(0, LW,    32'h20,   32'h0,        5'd0, 32'h0);
    vecs[16] = mk(0, LH,    32'h15,   32'h0,        5'd4, 32'h0);
    vecs[17] = mk(0, LB,    32'h3FFF, 32'h0,        5'd0, 32'h0);
    vecs[18] = mk(0, LW,    32'h4000, 32'h0,        5'd4, 32'h0);
    vecs[19] = mk(0, ADDIU, 32'h11,   32'h0,        5'd0, 32'h0);
    vecs[20] = mk(0, SB,    32'h17,   32'h000000AB, 5'd0, 32'h0);
    vecs[21] = mk(0, LW,    32'h14,   32'h0,        5'd0, 32'hAB010000);
    vecs[22] = mk(0, SH,    32'h14,   32'hFFFF7FFE, 5'd0, 32'h0);
    vecs[23] = mk(0, LH,    32'h14,   32'h0,        5'd0, 32'h00007FFE);
    vecs[24] = mk(0, LB,    32'h17,   32'h0,        5'd0, 32'hFFFFFFAB);
    vecs[25] = mk(1, LW,    32'h10,   32'h0,        5'd0, 32'h0);

    drive(1'b1, 1'b0, ADDIU, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(posedge clk); #1;
    checkResetState("reset");

    // Memory word 0 reads as zero right after reset
    drive(1'b0, 1'b0, LW, 32'h0, 32'h0, 32'h2000, 1'b1, 1'b1);
    @(negedge clk);
    chk("reset ExcM", {27'h0, ExcM}, 32'h0);
    @(posedge clk); #1;
    chk("reset mem0", DMOutW, 32'h0);
    chk("reset-next movWriteW", {31'h0, movWriteW}, 32'h1);
    expPc4 = 32'h2000;

    for (int i = 0; i < NV; i++) begin
      v     = vecs[i];
      instr = {v.op, 26'h2A51234};
      pc4   = 32'h1000 + 32'(4 * i);
      mw    = (i % 2) == 1;
      bw    = ((i / 2) % 2) == 1;
      drive(1'b0, v.intr, v.op, v.addr, v.data, pc4, mw, bw);
      @(negedge clk);
      chk($sformatf("v%0d ExcM", i), {27'h0, ExcM}, {27'h0, v.exc});
      @(posedge clk); #1;
      bubble = v.intr || (v.exc != 5'd0);
      if (!v.intr) expPc4 = pc4;
      chk($sformatf("v%0d InstrW", i),   InstrW,  bubble ? 32'h0 : instr);
      chk($sformatf("v%0d DMOutW", i),   DMOutW,  v.dm);
      chk($sformatf("v%0d ALUOutW", i),  ALUOutW, v.intr ? 32'h0 : v.addr);
      chk($sformatf("v%0d PCplus4W", i), PCplus4W, expPc4);
      chk($sformatf("v%0d PCplus8W", i), PCplus8W, expPc4 + 32'd4);
      chk($sformatf("v%0d movWriteW", i), {31'h0, movWriteW},
          {31'h0, mw && !bubble});
      chk($sformatf("v%0d bWriteW", i),   {31'h0, bWriteW},
          {31'h0, bw && !bubble});
    end

    // Reset dominates Int and suppresses a store on the same edge
    drive(1'b1, 1'b1, SW, 32'h30, 32'hCAFEF00D, 32'h5000, 1'b1, 1'b1);
    @(posedge clk); #1;
    checkResetState("reset+int");

    drive(1'b0, 1'b0, LW, 32'h30, 32'h0, 32'h5004, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("reset-suppressed store", DMOutW, 32'h0);

    drive(1'b0, 1'b0, LW, 32'h10, 32'h0, 32'h5008, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("reset clears memory", DMOutW, 32'h0);
    chk("post-reset PCplus4W", PCplus4W, 32'h5008);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
